// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-side control bundle between the pipeline and the hazard unit
// Counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
);
  localparam int FWD_W = $clog2(NSTAGE - 2 + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_src0_addr;
  logic              id_src0_used;
  logic [REG_AW-1:0] id_src1_addr;
  logic              id_src1_used;
  logic [REG_AW-1:0] id_dst_addr;
  logic              id_wb_we;
  logic              id_is_load;
  logic              id_is_hlt;
  logic              ex_branch_taken;
  logic              pc_stall;
  logic              if_id_stall;
  logic              id_ex_bubble;
  logic              flush_if_id;
  logic [FWD_W-1:0]  fwd_sel0;
  logic [FWD_W-1:0]  fwd_sel1;
  logic              hlt;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  modport master (
    output id_valid, id_src0_addr, id_src0_used, id_src1_addr, id_src1_used,
           id_dst_addr, id_wb_we, id_is_load, id_is_hlt, ex_branch_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, flush_if_id, fwd_sel0, fwd_sel1, hlt
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_src0_addr, id_src0_used, id_src1_addr, id_src1_used,
           id_dst_addr, id_wb_we, id_is_load, id_is_hlt, ex_branch_taken,
    output pc_stall, if_id_stall, id_ex_bubble, flush_if_id, fwd_sel0, fwd_sel1, hlt
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/forwarding/flush/halt-drain control for the in-order pipe
// Optional saturating perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int NSTAGE = 5,
  parameter int REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int SLOTS = NSTAGE - 2;
  localparam int FWD_W = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              we;
    logic              load;
    logic              hlt;
  } slot_t;

  state_t     state;
  slot_t      slot [1:SLOTS];
  logic       hlt_q;
  logic       load_use;
  logic       stall;
  logic       bubble;
  logic       issue;
  logic       hlt_issue;
  logic [FWD_W-1:0] sel0;
  logic [FWD_W-1:0] sel1;

  // Scan oldest to youngest so the youngest matching producer overwrites.
  always_comb begin
    sel0 = '0;
    sel1 = '0;
    for (int k = SLOTS; k >= 1; k--) begin
      if (slot[k].valid && slot[k].we && hz.id_src0_used && slot[k].dst == hz.id_src0_addr)
        sel0 = FWD_W'(k);
      if (slot[k].valid && slot[k].we && hz.id_src1_used && slot[k].dst == hz.id_src1_addr)
        sel1 = FWD_W'(k);
    end
  end

  always_comb begin
    load_use  = (state == RUN) && slot[1].valid && slot[1].load &&
                ((hz.id_src0_used && slot[1].dst == hz.id_src0_addr) ||
                 (hz.id_src1_used && slot[1].dst == hz.id_src1_addr));
    stall     = load_use && !hz.ex_branch_taken;
    bubble    = hz.ex_branch_taken || stall;
    issue     = hz.id_valid && !bubble && (state == RUN);
    hlt_issue = issue && hz.id_is_hlt;
  end

  assign hz.fwd_sel0     = sel0;
  assign hz.fwd_sel1     = sel1;
  assign hz.if_id_stall  = stall;
  assign hz.id_ex_bubble = bubble;
  assign hz.pc_stall     = stall || hlt_issue || (state != RUN);
  assign hz.flush_if_id  = hz.ex_branch_taken || (state != RUN);
  assign hz.hlt          = hlt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      hlt_q <= 1'b0;
      for (int k = 1; k <= SLOTS; k++) slot[k] <= '0;
    end else begin
      for (int k = SLOTS; k >= 2; k--) slot[k] <= slot[k-1];
      slot[1].valid <= issue;
      slot[1].dst   <= issue ? hz.id_dst_addr : '0;
      slot[1].we    <= issue && hz.id_wb_we;
      slot[1].load  <= issue && hz.id_is_load;
      slot[1].hlt   <= hlt_issue;
      case (state)
        RUN:    if (hlt_issue) state <= DRAIN;
        DRAIN: begin
          // The HLT entry reaching the oldest slot means everything ahead has retired.
          if (slot[SLOTS].valid && slot[SLOTS].hlt) begin
            state <= HALTED;
            hlt_q <= 1'b1;
          end
        end
        HALTED: hlt_q <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (hz.ex_branch_taken && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;
  localparam int NSTAGE = 5;
  localparam int REG_AW = 5;
  localparam int SLOTS  = NSTAGE - 2;

  typedef struct {
    bit           v;
    bit [REG_AW-1:0] d;
    bit           we;
    bit           ld;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .REG_AW(REG_AW)) hz ();
  pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .REG_AW(REG_AW)) dut (.clk(clk), .rst(rst), .hz(hz));

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  int   drain_left = 0;
  bit   halted = 0;
  int   stall_exp = 0;
  int   flush_exp = 0;
  bit   m_issue, m_hlt_issue, m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_of(input bit used, input bit [REG_AW-1:0] a);
    for (int k = 0; k < SLOTS; k++)
      if (used && q[k].v && q[k].we && q[k].d == a) return k + 1;
    return 0;
  endfunction

  task automatic drive(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                       input int d, input bit we, input bit ld, input bit h, input bit br);
    hz.id_valid = v;  hz.id_src0_addr = REG_AW'(s0); hz.id_src0_used = u0;
    hz.id_src1_addr = REG_AW'(s1); hz.id_src1_used = u1; hz.id_dst_addr = REG_AW'(d);
    hz.id_wb_we = we; hz.id_is_load = ld; hz.id_is_hlt = h; hz.ex_branch_taken = br;
    #1;
  endtask

  task automatic check_model(input string tag);
    bit run, lu;
    run = !halted && drain_left == 0;
    lu  = run && q[0].v && q[0].ld &&
          ((hz.id_src0_used && q[0].d == hz.id_src0_addr) ||
           (hz.id_src1_used && q[0].d == hz.id_src1_addr));
    m_stall     = lu && !hz.ex_branch_taken;
    m_issue     = hz.id_valid && !hz.ex_branch_taken && !m_stall && run;
    m_hlt_issue = m_issue && hz.id_is_hlt;
    chk({tag, ".fwd0"}, 32'(hz.fwd_sel0), fwd_of(hz.id_src0_used, hz.id_src0_addr));
    chk({tag, ".fwd1"}, 32'(hz.fwd_sel1), fwd_of(hz.id_src1_used, hz.id_src1_addr));
    chk({tag, ".pc_stall"}, 32'(hz.pc_stall), 32'(m_stall || m_hlt_issue || !run));
    chk({tag, ".if_id_stall"}, 32'(hz.if_id_stall), 32'(m_stall));
    chk({tag, ".bubble"}, 32'(hz.id_ex_bubble), 32'(m_stall || hz.ex_branch_taken));
    chk({tag, ".flush"}, 32'(hz.flush_if_id), 32'(hz.ex_branch_taken || !run));
    chk({tag, ".hlt"}, 32'(hz.hlt), 32'(halted));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, hz.stall_cnt, stall_exp);
    chk({tag, ".flush_cnt"}, hz.flush_cnt, flush_exp);
`endif
  endtask

  task automatic tick();
    ent_t e;
    check_model("m");
    @(posedge clk);
    if (!rst) begin
      q.delete();
      for (int k = 0; k < SLOTS; k++) q.push_back('{0, 0, 0, 0});
      drain_left = 0; halted = 0; stall_exp = 0; flush_exp = 0;
    end else begin
      stall_exp += int'(m_stall);
      flush_exp += int'(hz.ex_branch_taken);
      if (!halted && drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) halted = 1;
      end else if (m_hlt_issue) begin
        drain_left = SLOTS;
      end
      e = '{m_issue, m_issue ? hz.id_dst_addr : '0, m_issue && hz.id_wb_we, m_issue && hz.id_is_load};
      void'(q.pop_back());
      q.push_front(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < SLOTS; k++) q.push_back('{0, 0, 0, 0});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
    chk("rst.pc_stall", 32'(hz.pc_stall), 0);
    chk("rst.fwd0", 32'(hz.fwd_sel0), 0);
    chk("rst.hlt", 32'(hz.hlt), 0);
    tick();
    // 1: ADD r3 then ADD r4,r3,r3
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
    chk("t1.fwd0", 32'(hz.fwd_sel0), 1);
    chk("t1.fwd1", 32'(hz.fwd_sel1), 1);
    chk("t1.stall", 32'(hz.pc_stall), 0);
    tick();
    // 2: LW r5 then ADD r6,r5,r1
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("t2.pc_stall", 32'(hz.pc_stall), 1);
    chk("t2.if_id_stall", 32'(hz.if_id_stall), 1);
    chk("t2.bubble", 32'(hz.id_ex_bubble), 1);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("t2.stall_gone", 32'(hz.pc_stall), 0);
    chk("t2.fwd0_mem", 32'(hz.fwd_sel0), 2);
    tick();
    // 3: r7 in EX and MEM, youngest wins
    idle(3);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    chk("t3.fwd0", 32'(hz.fwd_sel0), 1);
    tick();
    // 4: load-use coincident with taken branch
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); tick();
    drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 1);
    chk("t4.flush", 32'(hz.flush_if_id), 1);
    chk("t4.bubble", 32'(hz.id_ex_bubble), 1);
    chk("t4.pc_stall", 32'(hz.pc_stall), 0);
    chk("t4.if_id_stall", 32'(hz.if_id_stall), 0);
    tick();
    // HLT squashed by a taken branch: stays in RUN
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sq.pc_stall", 32'(hz.pc_stall), 0);
    chk("sq.flush", 32'(hz.flush_if_id), 0);
    tick();
    // 5: HLT drain, hlt rises 3 edges after issue
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5.issue_stall", 32'(hz.pc_stall), 1);
    tick();
    for (int c = 1; c <= 6; c++) begin
      drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
      chk($sformatf("t5.hlt_c%0d", c), 32'(hz.hlt), 32'(c >= 4));
      chk($sformatf("t5.pc_c%0d", c), 32'(hz.pc_stall), 1);
      chk($sformatf("t5.flush_c%0d", c), 32'(hz.flush_if_id), 1);
      tick();
    end
    // 6: reset pulse during DRAIN
    rst = 1'b0; idle(1); rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    idle(1);
    rst = 1'b0; idle(1); rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6.pc_stall", 32'(hz.pc_stall), 0);
    chk("t6.flush", 32'(hz.flush_if_id), 0);
    chk("t6.hlt", 32'(hz.hlt), 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    chk("t6.run_fwd", 32'(hz.fwd_sel0), 1);
    tick();
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
